// File: rtl/ibex_data_bus_arbiter.sv
// Shares the core data-memory port (req/gnt/rvalid) between the LSU and a
// secondary master (DMA/debug). The selected request is forwarded to the bus
// combinationally. An in-order owner FIFO routes each response back to the
// master that issued it, and lsu_lock_i keeps split LSU accesses atomic.
//
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   lsu_*_i / lsu_*_o       LSU request (addr/we/be/wdata/lock), gnt/rvalid/err
//   dma_*_i / dma_*_o       secondary master request, gnt/rvalid/err
//   rdata_o                 bus read data passed through to both masters
//   data_*_o / data_*_i     shared data bus request and response
//   outstanding_o           owner FIFO occupancy
//   spurious_rvalid_o       sticky flag: response seen with no owner queued
module ibex_data_bus_arbiter #(
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        lsu_req_i,
    input  logic [31:0] lsu_addr_i,
    input  logic        lsu_we_i,
    input  logic [3:0]  lsu_be_i,
    input  logic [31:0] lsu_wdata_i,
    input  logic        lsu_lock_i,
    output logic        lsu_gnt_o,
    output logic        lsu_rvalid_o,
    output logic        lsu_err_o,

    input  logic        dma_req_i,
    input  logic [31:0] dma_addr_i,
    input  logic        dma_we_i,
    input  logic [3:0]  dma_be_i,
    input  logic [31:0] dma_wdata_i,
    output logic        dma_gnt_o,
    output logic        dma_rvalid_o,
    output logic        dma_err_o,

    output logic [31:0] rdata_o,

    output logic        data_req_o,
    output logic [31:0] data_addr_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_wdata_o,
    input  logic        data_gnt_i,
    input  logic        data_rvalid_i,
    input  logic        data_err_i,
    input  logic [31:0] data_rdata_i,

    output logic [2:0]  outstanding_o,
    output logic        spurious_rvalid_o
);

    localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [2:0]       DEPTH    = 3'(MAX_OUTSTANDING);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUTSTANDING - 1);

    localparam logic [1:0] ARB_IDLE = 2'd0;
    localparam logic [1:0] ARB_LSU  = 2'd1;
    localparam logic [1:0] ARB_DMA  = 2'd2;

    // Owner id encoding: 0 = LSU, 1 = DMA (also used for the rr pointer).
    logic [1:0]       state_q, state_d;
    logic             rr_q, rr_d;
    logic             owner_q [MAX_OUTSTANDING];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [2:0]       count_q;
    logic             spurious_q;

    logic sel_dma, sel_req, fifo_full, fifo_empty, bus_req, bus_gnt, head_dma, rsp_ok;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    // Requester selection: frozen owner while a request is pending, else round-robin.
    always_comb begin
        sel_dma = 1'b0;
        case (state_q)
            ARB_LSU: sel_dma = 1'b0;
            ARB_DMA: sel_dma = 1'b1;
            default: sel_dma = rr_q ? (dma_req_i | ~lsu_req_i) : (dma_req_i & ~lsu_req_i);
        endcase
    end

    assign sel_req    = sel_dma ? dma_req_i : lsu_req_i;
    assign fifo_full  = (count_q == DEPTH);
    assign fifo_empty = (count_q == 3'd0);
    // Full blocks requests regardless of a same-cycle pop: no rvalid->req path.
    assign bus_req    = sel_req & ~fifo_full & ~rst_i;
    assign bus_gnt    = bus_req & data_gnt_i;
    assign head_dma   = owner_q[rd_ptr_q];
    assign rsp_ok     = data_rvalid_i & ~fifo_empty & ~rst_i;

    // Bus-side mux.
    assign data_req_o   = bus_req;
    assign data_addr_o  = sel_dma ? dma_addr_i  : lsu_addr_i;
    assign data_we_o    = sel_dma ? dma_we_i    : lsu_we_i;
    assign data_be_o    = sel_dma ? dma_be_i    : lsu_be_i;
    assign data_wdata_o = sel_dma ? dma_wdata_i : lsu_wdata_i;

    // Master-side grant and response routing.
    assign lsu_gnt_o    = bus_gnt & ~sel_dma;
    assign dma_gnt_o    = bus_gnt &  sel_dma;
    assign lsu_rvalid_o = rsp_ok & ~head_dma;
    assign dma_rvalid_o = rsp_ok &  head_dma;
    assign lsu_err_o    = lsu_rvalid_o & data_err_i;
    assign dma_err_o    = dma_rvalid_o & data_err_i;
    assign rdata_o      = data_rdata_i;

    assign outstanding_o     = count_q;
    assign spurious_rvalid_o = spurious_q;

    // Next-state and round-robin pointer update.
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        case (state_q)
            ARB_IDLE: begin
                if (bus_gnt) begin
                    if (!sel_dma && lsu_lock_i) state_d = ARB_LSU;
                    else                        rr_d    = ~sel_dma;
                end else if (sel_req) begin
                    state_d = sel_dma ? ARB_DMA : ARB_LSU;
                end
            end
            ARB_LSU: begin
                if ((bus_gnt && !lsu_lock_i) || (!lsu_req_i && !lsu_lock_i)) begin
                    state_d = ARB_IDLE;
                    rr_d    = 1'b1;
                end
            end
            ARB_DMA: begin
                if (bus_gnt) begin
                    state_d = ARB_IDLE;
                    rr_d    = 1'b0;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // State, owner FIFO and sticky spurious flag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ARB_IDLE;
            rr_q       <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= 3'd0;
            spurious_q <= 1'b0;
            for (int i = 0; i < int'(MAX_OUTSTANDING); i++) owner_q[i] <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            if (bus_gnt) begin
                owner_q[wr_ptr_q] <= sel_dma;
                wr_ptr_q          <= ptr_inc(wr_ptr_q);
            end
            if (rsp_ok) rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({bus_gnt, rsp_ok})
                2'b10:   count_q <= count_q + 3'd1;
                2'b01:   count_q <= count_q - 3'd1;
                default: count_q <= count_q;
            endcase
            if (data_rvalid_i && fifo_empty) spurious_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ibex_data_bus_arbiter.sv
// Directed, table-driven bench for ibex_data_bus_arbiter. Inputs change on the
// falling edge; combinational outputs and register state are sampled 1 time
// unit later, well away from the rising edge.
module tb_ibex_data_bus_arbiter;

    localparam logic [31:0] LSU_ADDR = 32'h0000_1000;
    localparam logic [31:0] DMA_ADDR = 32'h0000_2000;
    localparam logic [31:0] LSU_WD   = 32'hAAAA_AAAA;
    localparam logic [31:0] DMA_WD   = 32'h5555_5555;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        lsu_req = 1'b0, lsu_lock = 1'b0, dma_req = 1'b0;
    logic        gnt = 1'b0, rvalid = 1'b0, err = 1'b0;
    logic [31:0] rdata_in = '0;

    logic        lsu_gnt, lsu_rvalid, lsu_err, dma_gnt, dma_rvalid, dma_err;
    logic [31:0] rdata_out, bus_addr, bus_wdata;
    logic        bus_req, bus_we, spurious;
    logic [3:0]  bus_be;
    logic [2:0]  outstanding;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ibex_data_bus_arbiter #(.MAX_OUTSTANDING(2)) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .lsu_req_i        (lsu_req),
        .lsu_addr_i       (LSU_ADDR),
        .lsu_we_i         (1'b1),
        .lsu_be_i         (4'hF),
        .lsu_wdata_i      (LSU_WD),
        .lsu_lock_i       (lsu_lock),
        .lsu_gnt_o        (lsu_gnt),
        .lsu_rvalid_o     (lsu_rvalid),
        .lsu_err_o        (lsu_err),
        .dma_req_i        (dma_req),
        .dma_addr_i       (DMA_ADDR),
        .dma_we_i         (1'b0),
        .dma_be_i         (4'h3),
        .dma_wdata_i      (DMA_WD),
        .dma_gnt_o        (dma_gnt),
        .dma_rvalid_o     (dma_rvalid),
        .dma_err_o        (dma_err),
        .rdata_o          (rdata_out),
        .data_req_o       (bus_req),
        .data_addr_o      (bus_addr),
        .data_we_o        (bus_we),
        .data_be_o        (bus_be),
        .data_wdata_o     (bus_wdata),
        .data_gnt_i       (gnt),
        .data_rvalid_i    (rvalid),
        .data_err_i       (err),
        .data_rdata_i     (rdata_in),
        .outstanding_o    (outstanding),
        .spurious_rvalid_o(spurious)
    );

    typedef struct {
        string      name;
        logic       rst, lreq, llock, dreq, gnt, rv, err;   // stimulus
        logic       e_req, e_dsel, e_lgnt, e_dgnt;          // expected bus side
        logic       e_lrv, e_drv, e_lerr, e_derr;           // expected responses
        logic [2:0] e_out;
        logic       e_spur;
    } vec_t;

    function automatic vec_t v(input string name,
                               input logic r, lr, lk, dr, g, rv, er,
                               input logic ereq, edsel, elg, edg, elrv, edrv, elerr, ederr,
                               input logic [2:0] eout, input logic espur);
        vec_t t;
        t.name = name; t.rst = r; t.lreq = lr; t.llock = lk; t.dreq = dr;
        t.gnt = g; t.rv = rv; t.err = er;
        t.e_req = ereq; t.e_dsel = edsel; t.e_lgnt = elg; t.e_dgnt = edg;
        t.e_lrv = elrv; t.e_drv = edrv; t.e_lerr = elerr; t.e_derr = ederr;
        t.e_out = eout; t.e_spur = espur;
        return t;
    endfunction

    task automatic chk(input string name, input string field,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s: got %h expected %h", name, field, act, exp);
        end
    endtask

    int vec_idx = 0;

    task automatic apply(input vec_t t);
        @(negedge clk);
        rst = t.rst; lsu_req = t.lreq; lsu_lock = t.llock; dma_req = t.dreq;
        gnt = t.gnt; rvalid = t.rv; err = t.err;
        rdata_in = 32'hD000_0000 + 32'(vec_idx);
        vec_idx++;
        #1;
        chk(t.name, "req",      32'(bus_req),     32'(t.e_req));
        chk(t.name, "lsu_gnt",  32'(lsu_gnt),     32'(t.e_lgnt));
        chk(t.name, "dma_gnt",  32'(dma_gnt),     32'(t.e_dgnt));
        chk(t.name, "lsu_rv",   32'(lsu_rvalid),  32'(t.e_lrv));
        chk(t.name, "dma_rv",   32'(dma_rvalid),  32'(t.e_drv));
        chk(t.name, "lsu_err",  32'(lsu_err),     32'(t.e_lerr));
        chk(t.name, "dma_err",  32'(dma_err),     32'(t.e_derr));
        chk(t.name, "outstd",   32'(outstanding), 32'(t.e_out));
        chk(t.name, "spurious", 32'(spurious),    32'(t.e_spur));
        chk(t.name, "rdata",    rdata_out,        rdata_in);
        if (t.e_req) begin
            chk(t.name, "addr",  bus_addr,  t.e_dsel ? DMA_ADDR : LSU_ADDR);
            chk(t.name, "we",    32'(bus_we), t.e_dsel ? 32'd0 : 32'd1);
            chk(t.name, "be",    32'(bus_be), t.e_dsel ? 32'h3 : 32'hF);
            chk(t.name, "wdata", bus_wdata, t.e_dsel ? DMA_WD : LSU_WD);
        end
    endtask

    vec_t vecs[$];

    initial begin
        //               name      rst lr lk dr g rv er  req ds lg dg lrv drv le de out sp
        vecs.push_back(v("rst",     1, 1, 0, 1, 1, 1, 1,  0, 0, 0, 0, 0, 0, 0, 0, 3'd0, 0));
        // LSU alone, grant same cycle, response next cycle
        vecs.push_back(v("t1_gnt",  0, 1, 0, 0, 1, 0, 0,  1, 0, 1, 0, 0, 0, 0, 0, 3'd0, 0));
        vecs.push_back(v("t1_rsp",  0, 0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 1, 0, 0, 0, 3'd1, 0));
        // Both requesting with permanent grant: alternate, responses in order
        vecs.push_back(v("t2_a",    0, 1, 0, 1, 1, 0, 0,  1, 1, 0, 1, 0, 0, 0, 0, 3'd0, 0));
        vecs.push_back(v("t2_b",    0, 1, 0, 1, 1, 1, 0,  1, 0, 1, 0, 0, 1, 0, 0, 3'd1, 0));
        vecs.push_back(v("t2_c",    0, 1, 0, 1, 1, 1, 1,  1, 1, 0, 1, 1, 0, 1, 0, 3'd1, 0));
        vecs.push_back(v("t2_d",    0, 0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0, 1, 0, 0, 3'd1, 0));
        // FIFO full blocks the bus request until a response drains it
        vecs.push_back(v("t4_g1",   0, 1, 0, 0, 1, 0, 0,  1, 0, 1, 0, 0, 0, 0, 0, 3'd0, 0));
        vecs.push_back(v("t4_g2",   0, 1, 0, 0, 1, 0, 0,  1, 0, 1, 0, 0, 0, 0, 0, 3'd1, 0));
        vecs.push_back(v("t4_full", 0, 1, 0, 0, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 3'd2, 0));
        vecs.push_back(v("t4_pop",  0, 1, 0, 0, 1, 1, 0,  0, 0, 0, 0, 1, 0, 0, 0, 3'd2, 0));
        vecs.push_back(v("t4_g3",   0, 1, 0, 0, 1, 0, 0,  1, 0, 1, 0, 0, 0, 0, 0, 3'd1, 0));
        vecs.push_back(v("t4_r2",   0, 0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 1, 0, 0, 0, 3'd2, 0));
        vecs.push_back(v("t4_r3",   0, 0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 1, 0, 0, 0, 3'd1, 0));
        // Locked split LSU access keeps DMA out until both halves are granted
        vecs.push_back(v("t3_d0",   0, 0, 0, 1, 1, 0, 0,  1, 1, 0, 1, 0, 0, 0, 0, 3'd0, 0));
        vecs.push_back(v("t3_l1",   0, 1, 1, 1, 1, 1, 0,  1, 0, 1, 0, 0, 1, 0, 0, 3'd1, 0));
        vecs.push_back(v("t3_l2",   0, 1, 0, 1, 1, 1, 0,  1, 0, 1, 0, 1, 0, 0, 0, 3'd1, 0));
        vecs.push_back(v("t3_d1",   0, 1, 0, 1, 1, 1, 0,  1, 1, 0, 1, 1, 0, 0, 0, 3'd1, 0));
        vecs.push_back(v("t3_rsp",  0, 0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0, 1, 0, 0, 3'd1, 0));
        // DMA waits for grant; bus stays on DMA even once LSU requests
        vecs.push_back(v("t5_w0",   0, 0, 0, 1, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0, 0, 3'd0, 0));
        vecs.push_back(v("t5_w1",   0, 1, 0, 1, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0, 0, 3'd0, 0));
        vecs.push_back(v("t5_w2",   0, 1, 0, 1, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0, 0, 3'd0, 0));
        vecs.push_back(v("t5_dg",   0, 1, 0, 1, 1, 0, 0,  1, 1, 0, 1, 0, 0, 0, 0, 3'd0, 0));
        vecs.push_back(v("t5_lg",   0, 1, 0, 0, 1, 1, 0,  1, 0, 1, 0, 0, 1, 0, 0, 3'd1, 0));
        vecs.push_back(v("t5_rsp",  0, 0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 1, 0, 0, 0, 3'd1, 0));
        // Spurious response on empty FIFO, then reset mid-transaction
        vecs.push_back(v("t6_sp",   0, 0, 0, 0, 0, 1, 1,  0, 0, 0, 0, 0, 0, 0, 0, 3'd0, 0));
        vecs.push_back(v("t6_g",    0, 1, 0, 0, 1, 0, 0,  1, 0, 1, 0, 0, 0, 0, 0, 3'd0, 1));
        vecs.push_back(v("t6_rst",  1, 1, 0, 0, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 3'd1, 1));
        vecs.push_back(v("t6_late", 0, 0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0, 0, 0, 0, 3'd0, 0));
        vecs.push_back(v("t6_idle", 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 3'd0, 1));

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

        // Locked LSU that drops its request between halves keeps ownership.
        apply(v("lk_a",   0, 1, 1, 1, 1, 0, 0,  1, 0, 1, 0, 0, 0, 0, 0, 3'd0, 1));
        apply(v("lk_gap", 0, 0, 1, 1, 1, 1, 0,  0, 0, 0, 0, 1, 0, 0, 0, 3'd1, 1));
        apply(v("lk_wt",  0, 1, 1, 1, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 3'd0, 1));
        apply(v("lk_b",   0, 1, 0, 1, 1, 0, 0,  1, 0, 1, 0, 0, 0, 0, 0, 3'd0, 1));
        apply(v("lk_dma", 0, 1, 0, 1, 1, 1, 0,  1, 1, 0, 1, 1, 0, 0, 0, 3'd1, 1));
        apply(v("lk_rsp", 0, 0, 0, 0, 0, 1, 1,  0, 0, 0, 0, 0, 1, 0, 1, 3'd1, 1));
        apply(v("lk_end", 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 3'd0, 1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
